dsi_tx_scheduler: RTL and testbench

Packet scheduler between the DSI front end (line FIFO, register-block command interface, hsync/vsync pulses) and the packetizer/lane manager. Each packet is one handshake. Sync short packets (VSS, HSS) go first, then video line long packets, then register-block commands. It also tracks line position within the frame, flags sync overruns and times out a stalled lane manager.

---
 rtl/dsi_pkg.sv | 28 ++
 rtl/dsi_watchdog.sv | 38 +++
 rtl/dsi_tx_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_dsi_tx_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI transmit scheduler: data types,
// scheduler states and the latched packet request.
package dsi_pkg;

  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_HSS    = 6'h21;
  localparam logic [5:0] DT_RGB888 = 6'h3E;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  // Which source the packet in flight came from, so its accept side effects land correctly.
  typedef enum logic [1:0] {SRC_VSS, SRC_HSS, SRC_LINE, SRC_CMD} src_t;

  typedef struct packed {
    logic        long_pkt;
    logic [7:0]  di;
    logic [15:0] wc;
  } pkt_req_t;

  function automatic pkt_req_t make_short(input logic [1:0] vc, input logic [5:0] dt);
    pkt_req_t r;
    r.long_pkt = 1'b0;
    r.di       = {vc, dt};
    r.wc       = 16'h0000;
    return r;
  endfunction

endpackage

// File: rtl/dsi_watchdog.sv
// Transfer watchdog: cleared by load, counts while enabled, and flags expire
// on the TIMEOUT-th enabled cycle.
import dsi_pkg::*;

module dsi_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dsi_tx_scheduler.sv
// DSI packet scheduler: arbitrates sync short packets, video line packets and
// register commands into one-at-a-time packetizer handshakes.
import dsi_pkg::*;

module dsi_tx_scheduler #(
  parameter int         FRAME_DEPTH = 720,
  parameter logic [1:0] VC          = 2'd0,
  parameter int         TIMEOUT     = 4096
) (
  input  logic                             dsi_clk,
  input  logic                             dsi_rst,
  input  logic                             video_en,
  input  logic                             vsync_p,
  input  logic                             hsync_p,
  input  logic                             line_ready,
  input  logic [15:0]                      line_wc,
  output logic                             line_ack,
  input  logic                             cmd_valid,
  input  logic [7:0]                       cmd_di,
  input  logic [15:0]                      cmd_wc,
  input  logic                             cmd_long,
  output logic                             cmd_ready,
  output logic                             pkt_valid,
  input  logic                             pkt_ready,
  output logic                             pkt_long,
  output logic [7:0]                       pkt_di,
  output logic [15:0]                      pkt_wc,
  input  logic                             pkt_done,
  output logic [$clog2(FRAME_DEPTH+1)-1:0] line_cnt,
  output logic                             frame_done,
  output logic                             busy,
  output logic                             sync_ovf,
  output logic                             timeout_err,
  input  logic                             err_clr
);

  localparam int LCW = $clog2(FRAME_DEPTH + 1);

  state_t         state_q, state_d;
  src_t           src_q, src_d;
  pkt_req_t       req_q, req_d;
  logic [LCW-1:0] line_cnt_q, line_cnt_d;
  logic           pend_vss_q, pend_vss_d, pend_hss_q, pend_hss_d;
  logic           line_armed_q, line_armed_d;
  logic           line_ack_q, line_ack_d, cmd_ready_q, cmd_ready_d;
  logic           frame_done_q, frame_done_d;
  logic           sync_ovf_q, sync_ovf_d, timeout_err_q, timeout_err_d;
  logic           pkt_valid_q, pkt_valid_d, busy_q, busy_d;
  logic           accept, acc_vss, acc_hss, acc_line, acc_cmd;
  logic           ovf_set, wd_expire, wd_en;

  assign wd_en = (state_q == WAIT_DONE);

  dsi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (dsi_clk),
    .rst_n  (dsi_rst),
    .load   (accept),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    accept   = pkt_valid_q && pkt_ready;
    acc_vss  = accept && (src_q == SRC_VSS);
    acc_hss  = accept && (src_q == SRC_HSS);
    acc_line = accept && (src_q == SRC_LINE);
    acc_cmd  = accept && (src_q == SRC_CMD);

    // An overrun is a pulse landing on a flag that is still owed a packet.
    ovf_set = video_en && ((vsync_p && pend_vss_q && !acc_vss) ||
                           (hsync_p && pend_hss_q && !acc_hss));
    pend_vss_d = video_en && ((pend_vss_q && !acc_vss) || vsync_p);
    pend_hss_d = video_en && ((pend_hss_q && !acc_hss) || hsync_p);

    line_armed_d = line_armed_q;
    if (!video_en || acc_vss || acc_line) begin
      line_armed_d = 1'b0;
    end else if (acc_hss) begin
      line_armed_d = 1'b1;
    end

    frame_done_d = 1'b0;
    line_cnt_d   = line_cnt_q;
    if (acc_vss) begin
      line_cnt_d = '0;
    end else if (acc_line) begin
      if (line_cnt_q == LCW'(FRAME_DEPTH - 1)) begin
        line_cnt_d   = '0;
        frame_done_d = 1'b1;
      end else begin
        line_cnt_d = line_cnt_q + 1'b1;
      end
    end

    line_ack_d    = acc_line;
    cmd_ready_d   = acc_cmd;
    sync_ovf_d    = (sync_ovf_q && !err_clr) || ovf_set;
    timeout_err_d = (timeout_err_q && !err_clr) || (wd_expire && !pkt_done);

    state_d = state_q;
    src_d   = src_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (video_en && pend_vss_q) begin
          state_d = ISSUE;
          src_d   = SRC_VSS;
          req_d   = make_short(VC, DT_VSS);
        end else if (video_en && pend_hss_q) begin
          state_d = ISSUE;
          src_d   = SRC_HSS;
          req_d   = make_short(VC, DT_HSS);
        end else if (video_en && line_ready && line_armed_q) begin
          state_d      = ISSUE;
          src_d        = SRC_LINE;
          req_d.long_pkt = 1'b1;
          req_d.di     = {VC, DT_RGB888};
          req_d.wc     = line_wc;
        end else if (cmd_valid) begin
          state_d        = ISSUE;
          src_d          = SRC_CMD;
          req_d.long_pkt = cmd_long;
          req_d.di       = cmd_di;
          req_d.wc       = cmd_wc;
        end
      end
      ISSUE: begin
        if (pkt_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A stalled lane manager forfeits the packet; nothing is re-queued.
        if (pkt_done || wd_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pkt_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge dsi_clk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      state_q       <= IDLE;
      src_q         <= SRC_VSS;
      req_q         <= '0;
      line_cnt_q    <= '0;
      pend_vss_q    <= 1'b0;
      pend_hss_q    <= 1'b0;
      line_armed_q  <= 1'b0;
      line_ack_q    <= 1'b0;
      cmd_ready_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_ovf_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      pkt_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      req_q         <= req_d;
      line_cnt_q    <= line_cnt_d;
      pend_vss_q    <= pend_vss_d;
      pend_hss_q    <= pend_hss_d;
      line_armed_q  <= line_armed_d;
      line_ack_q    <= line_ack_d;
      cmd_ready_q   <= cmd_ready_d;
      frame_done_q  <= frame_done_d;
      sync_ovf_q    <= sync_ovf_d;
      timeout_err_q <= timeout_err_d;
      pkt_valid_q   <= pkt_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign line_ack    = line_ack_q;
  assign cmd_ready   = cmd_ready_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_long    = req_q.long_pkt;
  assign pkt_di      = req_q.di;
  assign pkt_wc      = req_q.wc;
  assign line_cnt    = line_cnt_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign sync_ovf    = sync_ovf_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dsi_tx_scheduler.sv
// Self-checking bench for dsi_tx_scheduler: scoreboarded packet stream, a
// table of sync/command vectors, and hand-written multi-cycle corner cases.
module tb_dsi_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, video_en, vsync_p, hsync_p, line_ready;
  logic [15:0] line_wc;
  logic        line_ack, cmd_valid, cmd_long, cmd_ready;
  logic [7:0]  cmd_di;
  logic [15:0] cmd_wc;
  logic        pkt_valid, pkt_ready, pkt_long, pkt_done;
  logic [7:0]  pkt_di;
  logic [15:0] pkt_wc;
  logic [2:0]  line_cnt;
  logic        frame_done, busy, sync_ovf, timeout_err, err_clr;

  int checks = 0;
  int failures = 0;
  int n_line_ack = 0;
  int n_cmd_ready = 0;
  int n_frame_done = 0;
  bit auto_done = 1'b1;

  typedef struct {
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          kind;   // 0 vsync, 1 hsync, 2 command
    logic [7:0]  di;
    logic [15:0] wc;
    logic        lng;
    logic [7:0]  exp_di;
    logic [15:0] exp_wc;
    logic        exp_lng;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  dsi_tx_scheduler #(.FRAME_DEPTH(4), .VC(2'd0), .TIMEOUT(16)) dut (
    .dsi_clk     (clk),
    .dsi_rst     (rst_n),
    .video_en    (video_en),
    .vsync_p     (vsync_p),
    .hsync_p     (hsync_p),
    .line_ready  (line_ready),
    .line_wc     (line_wc),
    .line_ack    (line_ack),
    .cmd_valid   (cmd_valid),
    .cmd_di      (cmd_di),
    .cmd_wc      (cmd_wc),
    .cmd_long    (cmd_long),
    .cmd_ready   (cmd_ready),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_long    (pkt_long),
    .pkt_di      (pkt_di),
    .pkt_wc      (pkt_wc),
    .pkt_done    (pkt_done),
    .line_cnt    (line_cnt),
    .frame_done  (frame_done),
    .busy        (busy),
    .sync_ovf    (sync_ovf),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(n < 300), 32'd1);
  endtask

  task automatic wait_cmd_ready(input string name);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] di, input logic [15:0] wc, input logic lng);
    exp_t e;
    e.di = di;
    e.wc = wc;
    e.lng = lng;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted packet must match the oldest expectation.
  initial begin : sb
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pkt actual_di=0x%0h required=none at %0t", pkt_di, $time);
        end else begin
          e = exp_q.pop_front();
          check("pkt_di", 32'(pkt_di), 32'(e.di));
          check("pkt_wc", 32'(pkt_wc), 32'(e.wc));
          check("pkt_long", 32'(pkt_long), 32'(e.lng));
        end
      end
    end
  end

  initial begin : pulse_count
    forever begin
      @(negedge clk);
      if (line_ack) n_line_ack++;
      if (cmd_ready) n_cmd_ready++;
      if (frame_done) n_frame_done++;
    end
  end

  initial begin : lane_model
    pkt_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && pkt_valid && pkt_ready && auto_done) begin
        repeat (5) @(negedge clk);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
      end
    end
  end

  initial begin : guard
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int base;
    rst_n = 1'b0; video_en = 1'b1; vsync_p = 1'b0; hsync_p = 1'b0;
    line_ready = 1'b0; line_wc = '0; cmd_valid = 1'b0; cmd_di = '0;
    cmd_wc = '0; cmd_long = 1'b0; pkt_ready = 1'b1; err_clr = 1'b0;

    vecs[0] = '{2, 8'h05, 16'h0011, 1'b0, 8'h05, 16'h0011, 1'b0};
    vecs[1] = '{2, 8'h39, 16'h0004, 1'b1, 8'h39, 16'h0004, 1'b1};
    vecs[2] = '{1, 8'h00, 16'h0000, 1'b0, 8'h21, 16'h0000, 1'b0};
    vecs[3] = '{0, 8'h00, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0};
    vecs[4] = '{2, 8'h15, 16'hBEEF, 1'b0, 8'h15, 16'hBEEF, 1'b0};

    tick(3);
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_cnt", 32'(line_cnt), 32'd0);
    check("rst_errors", 32'({sync_ovf, timeout_err}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame start: VSS, HSS, then the first line.
    vsync_p = 1'b1; push(8'h01, 16'h0000, 1'b0);
    tick();
    vsync_p = 1'b0; hsync_p = 1'b1; push(8'h21, 16'h0000, 1'b0);
    tick();
    hsync_p = 1'b0; line_ready = 1'b1; line_wc = 16'd3840; push(8'h3E, 16'd3840, 1'b1);
    wait_idle("frame_start_idle");
    line_ready = 1'b0;
    check("frame_start_line_ack", 32'(n_line_ack), 32'd1);
    check("frame_start_line_cnt", 32'(line_cnt), 32'd1);

    // Pulse-to-valid latency and request stability under back-pressure.
    pkt_ready = 1'b0;
    hsync_p = 1'b1; push(8'h21, 16'h0000, 1'b0);
    tick();
    hsync_p = 1'b0;
    check("latency_n1_valid", 32'(pkt_valid), 32'd0);
    tick();
    check("latency_n2_valid", 32'(pkt_valid), 32'd1);
    tick(3);
    check("stall_valid_held", 32'(pkt_valid), 32'd1);
    check("stall_di_held", 32'(pkt_di), 32'h21);
    pkt_ready = 1'b1;
    wait_idle("stall_idle");

    // Same-cycle syncs: VSS strictly before HSS, no overrun.
    vsync_p = 1'b1; hsync_p = 1'b1;
    push(8'h01, 16'h0000, 1'b0); push(8'h21, 16'h0000, 1'b0);
    tick();
    vsync_p = 1'b0; hsync_p = 1'b0;
    wait_idle("dual_sync_idle");
    check("dual_sync_ovf", 32'(sync_ovf), 32'd0);
    check("vss_resets_line_cnt", 32'(line_cnt), 32'd0);

    for (int i = 0; i < 5; i++) begin
      base = n_cmd_ready;
      push(vecs[i].exp_di, vecs[i].exp_wc, vecs[i].exp_lng);
      if (vecs[i].kind == 2) begin
        cmd_di = vecs[i].di; cmd_wc = vecs[i].wc; cmd_long = vecs[i].lng; cmd_valid = 1'b1;
        wait_cmd_ready("vec_cmd_ready");
      end else begin
        vsync_p = (vecs[i].kind == 0);
        hsync_p = (vecs[i].kind == 1);
        tick();
        vsync_p = 1'b0; hsync_p = 1'b0;
      end
      wait_idle("vec_idle");
      check("vec_cmd_ready_count", 32'(n_cmd_ready - base), 32'(vecs[i].kind == 2));
    end

    // Command raised while an HSS is pending: HSS goes first.
    base = n_cmd_ready;
    hsync_p = 1'b1; push(8'h21, 16'h0000, 1'b0); push(8'h05, 16'h0011, 1'b0);
    tick();
    hsync_p = 1'b0; cmd_di = 8'h05; cmd_wc = 16'h0011; cmd_long = 1'b0; cmd_valid = 1'b1;
    wait_cmd_ready("arb_cmd_ready");
    wait_idle("arb_idle");
    check("arb_cmd_ready_once", 32'(n_cmd_ready - base), 32'd1);

    // Frame wrap after four lines.
    vsync_p = 1'b1; push(8'h01, 16'h0000, 1'b0);
    tick();
    vsync_p = 1'b0;
    wait_idle("wrap_vss_idle");
    base = n_frame_done;
    for (int i = 0; i < 4; i++) begin
      hsync_p = 1'b1; push(8'h21, 16'h0000, 1'b0);
      tick();
      hsync_p = 1'b0; line_ready = 1'b1; line_wc = 16'(100 + i);
      push(8'h3E, 16'(100 + i), 1'b1);
      wait_idle("wrap_line_idle");
      line_ready = 1'b0;
      check("wrap_line_cnt", 32'(line_cnt), 32'((i + 1) % 4));
      check("wrap_frame_done", 32'(n_frame_done - base), 32'(i == 3));
    end

    // Watchdog: lane manager never reports done.
    auto_done = 1'b0;
    cmd_di = 8'h09; cmd_wc = 16'h0000; cmd_long = 1'b0; cmd_valid = 1'b1;
    push(8'h09, 16'h0000, 1'b0);
    wait_cmd_ready("wd_cmd_ready");
    tick(15);
    check("wd_still_busy", 32'(busy), 32'd1);
    check("wd_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_err_set", 32'(timeout_err), 32'd1);
    tick(3);
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd_err_cleared", 32'(timeout_err), 32'd0);

    // Video disabled: sync pulses are dropped.
    video_en = 1'b0;
    hsync_p = 1'b1;
    tick();
    hsync_p = 1'b0;
    tick(3);
    check("video_off_busy", 32'(busy), 32'd0);
    video_en = 1'b1;
    tick();

    // Overrun during a stalled packet, then reset while in WAIT_DONE.
    cmd_di = 8'h0A; cmd_wc = 16'h1234; cmd_long = 1'b1; cmd_valid = 1'b1;
    push(8'h0A, 16'h1234, 1'b1);
    wait_cmd_ready("ovf_cmd_ready");
    hsync_p = 1'b1;
    tick();
    hsync_p = 1'b0;
    tick();
    check("ovf_first_pulse", 32'(sync_ovf), 32'd0);
    hsync_p = 1'b1; err_clr = 1'b1;
    tick();
    hsync_p = 1'b0; err_clr = 1'b0;
    check("ovf_set_beats_clr", 32'(sync_ovf), 32'd1);
    tick();
    check("ovf_sticky", 32'(sync_ovf), 32'd1);
    check("ovf_busy_wait_done", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sync_ovf", 32'(sync_ovf), 32'd0);
    check("midrst_pkt_fields", 32'({pkt_long, pkt_di, pkt_wc}), 32'd0);
    check("midrst_pulses", 32'({pkt_valid, line_ack, cmd_ready, frame_done, timeout_err}), 32'd0);
    check("midrst_line_cnt", 32'(line_cnt), 32'd0);
    rst_n = 1'b1;
    auto_done = 1'b1;
    tick(5);
    check("post_rst_pending_cleared", 32'(busy), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
